// File: rtl/alien_a.sv
`default_nettype none
// ============================================================================
// Module   : alien_a
// Purpose  : Sprite generator for a row of five identical "model A" invaders.
//            Holds the formation position (march, edge bounce, drop) and, for
//            the current scan pixel, reports which alien box contains it and
//            whether the 16x16 bitmap pixel there is lit.
// Ports    : clk            - pixel clock
//            rst            - asynchronous, active-high reset
//            pixel_row      - current scan row (12 bit)
//            pixel_column   - current scan column (12 bit)
//            alienA_output  - 4'hF when the pixel is a lit alien pixel, else 4'h0
//            alienA1_active .. alienA5_active - pixel inside alien n's box
// Config   : ALIEN_ANIM_EN - when defined, a second bitmap frame is shown on
//            alternate march steps; when undefined frame 0 is always shown.
// Revision : 1.0 - initial release
// ============================================================================
module alien_a #(
    parameter int X_START     = 64,
    parameter int Y_START     = 48,
    parameter int SCALE       = 2,
    parameter int PITCH       = 64,
    parameter int STEP        = 4,
    parameter int DROP        = 8,
    parameter int MOVE_FRAMES = 8,
    parameter int LEFT_BOUND  = 16,
    parameter int RIGHT_BOUND = 640,
    parameter int Y_MAX       = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    output logic [3:0]  alienA_output,
    output logic        alienA1_active,
    output logic        alienA2_active,
    output logic        alienA3_active,
    output logic        alienA4_active,
    output logic        alienA5_active
);

    localparam int W      = 16 * SCALE;
    localparam int H      = 16 * SCALE;
    localparam int SPAN   = 4 * PITCH + W;
    localparam int FC_W   = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [11:0]     x_q, x_d;
    logic [11:0]     y_q, y_d;
    logic            dir_q, dir_d;          // 0 = marching right
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            prev_zero_q, prev_zero_d;
`ifdef ALIEN_ANIM_EN
    logic            anim_q, anim_d;
`endif

    logic        w_at_origin;
    logic        w_frame_tick;
    logic [12:0] w_y_drop;

    assign w_at_origin  = (pixel_row == 12'd0) && (pixel_column == 12'd0);
    // One tick per frame: only on the first clock that sees the origin.
    assign w_frame_tick = w_at_origin && !prev_zero_q;
    assign w_y_drop     = {1'b0, y_q} + 13'(DROP);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;
        prev_zero_d = w_at_origin;
`ifdef ALIEN_ANIM_EN
        anim_d      = anim_q;
`endif
        if (w_frame_tick) begin
            if (frame_cnt_q == FC_W'(MOVE_FRAMES - 1)) begin
                frame_cnt_d = '0;
`ifdef ALIEN_ANIM_EN
                anim_d      = ~anim_q;
`endif
                // 13-bit compare so the right-edge test cannot wrap.
                if (!dir_q && (({1'b0, x_q} + 13'(SPAN + STEP)) <= 13'(RIGHT_BOUND))) begin
                    x_d = x_q + 12'(STEP);
                end else if (dir_q && (x_q >= 12'(LEFT_BOUND + STEP))) begin
                    x_d = x_q - 12'(STEP);
                end else begin
                    // Edge hit: reverse and drop one row, x holds.
                    dir_d = ~dir_q;
                    y_d   = (w_y_drop > 13'(Y_MAX)) ? 12'(Y_MAX) : w_y_drop[11:0];
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= 12'(X_START);
            y_q         <= 12'(Y_START);
            dir_q       <= 1'b0;
            frame_cnt_q <= '0;
            prev_zero_q <= 1'b1;
`ifdef ALIEN_ANIM_EN
            anim_q      <= 1'b0;
`endif
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            frame_cnt_q <= frame_cnt_d;
            prev_zero_q <= prev_zero_d;
`ifdef ALIEN_ANIM_EN
            anim_q      <= anim_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Bitmaps (bit 15 is the leftmost pixel of a row)
    // ------------------------------------------------------------------------
    function automatic logic [15:0] frame0_row(input logic [3:0] r);
        case (r)
            4'd4:    frame0_row = 16'h0810;
            4'd5:    frame0_row = 16'h0420;
            4'd6:    frame0_row = 16'h0FF0;
            4'd7:    frame0_row = 16'h1BD8;
            4'd8:    frame0_row = 16'h3FFC;
            4'd9:    frame0_row = 16'h2FF4;
            4'd10:   frame0_row = 16'h2814;
            4'd11:   frame0_row = 16'h0660;
            default: frame0_row = 16'h0000;
        endcase
    endfunction

`ifdef ALIEN_ANIM_EN
    function automatic logic [15:0] frame1_row(input logic [3:0] r);
        case (r)
            4'd4:    frame1_row = 16'h0810;
            4'd5:    frame1_row = 16'h2424;
            4'd6:    frame1_row = 16'h2FF4;
            4'd7:    frame1_row = 16'h3BDC;
            4'd8:    frame1_row = 16'h3FFC;
            4'd9:    frame1_row = 16'h1FF8;
            4'd10:   frame1_row = 16'h0810;
            4'd11:   frame1_row = 16'h1008;
            default: frame1_row = 16'h0000;
        endcase
    endfunction
`endif

    // ------------------------------------------------------------------------
    // Pixel hit test (combinational, zero latency)
    // ------------------------------------------------------------------------
    logic [12:0] w_row13;
    logic [12:0] w_col13;
    logic [12:0] w_y13;
    logic [3:0]  w_r;
    logic [15:0] w_row_bits;
    logic [4:0]  w_act;
    logic [4:0]  w_lit;

    assign w_row13 = {1'b0, pixel_row};
    assign w_col13 = {1'b0, pixel_column};
    assign w_y13   = {1'b0, y_q};
    // Bitmap row is shared by all aliens; only meaningful while inside a box.
    assign w_r     = 4'((w_row13 - w_y13) / 13'(SCALE));

`ifdef ALIEN_ANIM_EN
    assign w_row_bits = anim_q ? frame1_row(w_r) : frame0_row(w_r);
`else
    assign w_row_bits = frame0_row(w_r);
`endif

    generate
        for (genvar n = 0; n < 5; n++) begin : g_alien
            logic [12:0] w_xn;
            logic [3:0]  w_c;
            assign w_xn = {1'b0, x_q} + 13'(n * PITCH);
            assign w_c  = 4'((w_col13 - w_xn) / 13'(SCALE));
            assign w_act[n] = (w_col13 >= w_xn) && (w_col13 < (w_xn + 13'(W))) &&
                              (w_row13 >= w_y13) && (w_row13 < (w_y13 + 13'(H)));
            // 15-c is the bitwise inverse of a 4-bit column index.
            assign w_lit[n] = w_act[n] && w_row_bits[~w_c];
        end
    endgenerate

    assign alienA1_active = w_act[0];
    assign alienA2_active = w_act[1];
    assign alienA3_active = w_act[2];
    assign alienA4_active = w_act[3];
    assign alienA5_active = w_act[4];
    assign alienA_output  = (|w_lit) ? 4'hF : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_alien_a.sv
`default_nettype none
// ============================================================================
// Module   : tb_alien_a
// Purpose  : Self-checking bench for alien_a. Directed scenarios (reset
//            position, bitmap lookup, march timing, right-edge bounce,
//            asynchronous reset, animation frame) plus random pixel probes
//            compared against a coordinate-level model of the formation.
// Config   : ALIEN_ANIM_EN - selects the expected bitmap frame behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alien_a;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] row, col;
    logic [3:0]  out;
    logic        a1, a2, a3, a4, a5;

    alien_a dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_row      (row),
        .pixel_column   (col),
        .alienA_output  (out),
        .alienA1_active (a1),
        .alienA2_active (a2),
        .alienA3_active (a3),
        .alienA4_active (a4),
        .alienA5_active (a5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: formation position tracked as plain integers.
    int mx, my, mdir, mcnt, manim;
    logic [15:0] bm0 [16];
    logic [15:0] bm1 [16];

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mx = 64; my = 48; mdir = 0; mcnt = 0; manim = 0;
    endtask

    task automatic model_tick();
        if (mcnt == 7) begin
            mcnt = 0;
            manim = 1 - manim;
            if (mdir == 0 && mx + 288 + 4 <= 640)      mx = mx + 4;
            else if (mdir == 1 && mx >= 20)            mx = mx - 4;
            else begin
                mdir = 1 - mdir;
                my = (my + 8 > 400) ? 400 : my + 8;
            end
        end else begin
            mcnt++;
        end
    endtask

    // Expected {lit, active5..active1} for a pixel.
    function automatic logic [5:0] expect_px(input int r, input int c);
        logic [5:0]  e;
        logic [15:0] bits;
        e = '0;
        for (int n = 0; n < 5; n++) begin
            int xn;
            xn = mx + 64 * n;
            if (c >= xn && c < xn + 32 && r >= my && r < my + 32) begin
                e[n] = 1'b1;
`ifdef ALIEN_ANIM_EN
                bits = (manim == 1) ? bm1[(r - my) / 2] : bm0[(r - my) / 2];
`else
                bits = bm0[(r - my) / 2];
`endif
                if (bits[15 - (c - xn) / 2]) e[5] = 1'b1;
            end
        end
        return e;
    endfunction

    // Drive a pixel mid-cycle and let the combinational outputs settle.
    task automatic set_px(input int r, input int c);
        @(negedge clk);
        row = 12'(r);
        col = 12'(c);
        #1;
    endtask

    task automatic probe(input int r, input int c);
        logic [5:0] e;
        if (r == 0 && c == 0) c = 1;   // never create an accidental frame tick
        set_px(r, c);
        e = expect_px(r, c);
        chk("probe_active", {7'd0, a5, a4, a3, a2, a1}, {7'd0, e[4:0]});
        chk("probe_pixel", {8'd0, out}, e[5] ? 12'hF : 12'h0);
    endtask

    task automatic probe_rand();
        int r, c;
        r = my - 4 + int'($urandom_range(0, 40));
        c = mx - 8 + int'($urandom_range(0, 304));
        probe(r, c);
    endtask

    // One frame start: origin for a single clock, then away from it.
    task automatic tick();
        @(negedge clk);
        row = 12'd0;
        col = 12'd0;
        @(negedge clk);
        row = 12'd1;
        col = 12'd1;
        model_tick();
    endtask

    initial begin
        bm0 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0810, 16'h0420, 16'h0FF0, 16'h1BD8,
                16'h3FFC, 16'h2FF4, 16'h2814, 16'h0660,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
        bm1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0810, 16'h2424, 16'h2FF4, 16'h3BDC,
                16'h3FFC, 16'h1FF8, 16'h0810, 16'h1008,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
        model_reset();
        rst = 1'b1;
        row = 12'd1;
        col = 12'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset position and box edges
        set_px(48, 64);  chk("rst_a1_left",  {11'd0, a1}, 12'd1);
        set_px(48, 95);  chk("rst_a1_right", {11'd0, a1}, 12'd1);
        set_px(48, 96);  chk("rst_a1_past",  {11'd0, a1}, 12'd0);
        set_px(48, 128); chk("rst_a2",       {11'd0, a2}, 12'd1);
        set_px(48, 320); chk("rst_a5",       {11'd0, a5}, 12'd1);
        set_px(47, 64);  chk("rst_above",    {11'd0, a1}, 12'd0);

        // Bitmap lookup
        set_px(56, 72);  chk("bm_lit", {8'd0, out}, 12'hF);
        set_px(56, 64);  chk("bm_dark_act", {11'd0, a1}, 12'd1);
                         chk("bm_dark_out", {8'd0, out}, 12'h0);

        for (int i = 0; i < 20; i++) probe_rand();

        // March timing: 7 ticks hold, 8th moves
        repeat (7) tick();
        set_px(48, 64);  chk("t7_hold", {11'd0, a1}, 12'd1);
        tick();
        set_px(48, 64);  chk("t8_left_gone", {11'd0, a1}, 12'd0);
        set_px(48, 68);  chk("t8_moved", {11'd0, a1}, 12'd1);

        // Animation frame selection after one step (bitmap row 5, col index 2)
        set_px(58, 72);
`ifdef ALIEN_ANIM_EN
        chk("anim_px", {8'd0, out}, 12'hF);
`else
        chk("anim_px", {8'd0, out}, 12'h0);
`endif

        // March to the right edge: 576 ticks total -> x=352
        for (int i = 0; i < 568; i++) begin
            tick();
            if (i % 29 == 0) probe_rand();
        end
        set_px(48, 352); chk("edge_x352",   {11'd0, a1}, 12'd1);
        set_px(48, 348); chk("edge_not348", {11'd0, a1}, 12'd0);
        set_px(48, 639); chk("edge_a5_end", {11'd0, a5}, 12'd1);

        // Step 73: bounce, drop, x holds
        repeat (8) tick();
        set_px(56, 352); chk("bounce_y56",  {11'd0, a1}, 12'd1);
        set_px(55, 352); chk("bounce_above", {11'd0, a1}, 12'd0);

        // Step 74: moving left
        repeat (8) tick();
        set_px(56, 348); chk("left_x348", {11'd0, a1}, 12'd1);
        set_px(56, 380); chk("left_edge", {11'd0, a1}, 12'd0);

        for (int i = 0; i < 10; i++) probe_rand();

        // Asynchronous reset mid-frame: outputs follow before any clock edge
        @(negedge clk);
        row = 12'd48;
        col = 12'd64;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_x64", {11'd0, a1}, 12'd1);
        col = 12'd348;
        #1;
        chk("arst_old_gone", {11'd0, a1}, 12'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // After reset the formation marches right again
        repeat (16) tick();
        set_px(48, 72); chk("arst_dir_right", {11'd0, a1}, 12'd1);
        set_px(48, 71); chk("arst_dir_edge",  {11'd0, a1}, 12'd0);

        for (int i = 0; i < 20; i++) begin
            tick();
            probe_rand();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
